// File: rtl/snax_gemm_result_serializer_pkg.sv
// Shared types and default widths for the GEMM result serializer.
package snax_gemm_ser_pkg;

   localparam int unsigned DefInWidth  = 2048;
   localparam int unsigned DefOutWidth = 512;
   localparam int unsigned DefCntWidth = 32;

   typedef enum logic [0:0] {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

   // Number of write beats needed to drain one result word.
   function automatic int unsigned ser_num_beats(input int unsigned in_w,
                                                 input int unsigned out_w);
      return in_w / out_w;
   endfunction

endpackage

// File: rtl/snax_gemm_result_serializer_if.sv
// Stream bundle between GEMM core, serializer and write streamer.
// Signal names are given from the serializer's point of view.
interface snax_gemm_result_serializer_if
   import snax_gemm_ser_pkg::*;
#(
   parameter int unsigned InWidth  = DefInWidth,
   parameter int unsigned OutWidth = DefOutWidth
);
   logic [InWidth-1:0]  in_data_i;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [OutWidth-1:0] out_data_o;
   logic                out_valid_o;
   logic                out_ready_i;

   // Serializer side
   modport slave (
      input  in_data_i, in_valid_i, out_ready_i,
      output in_ready_o, out_data_o, out_valid_o
   );

   // Producer/consumer side
   modport master (
      output in_data_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_data_o, out_valid_o
   );
endinterface

// File: rtl/snax_gemm_result_serializer_stall_counter.sv
// Saturating, synchronously clearable event counter used to measure
// output backpressure. Only built when SNAX_GEMM_SERIALIZER_STALL_CNT_EN
// is defined.
module snax_gemm_ser_stall_counter #(
   parameter int unsigned CntWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                en_i,
   output logic [CntWidth-1:0] cnt_o
);
   logic [CntWidth-1:0] cnt_q, cnt_d;

   // Clear wins; otherwise count events and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CntWidth'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/snax_gemm_result_serializer.sv
// Splits one wide GEMM result word into InWidth/OutWidth streamer beats,
// LSB slice first. A new word can be loaded in the same cycle as the last
// beat handshake so back-to-back words stream without a bubble.
// Optional feature: define SNAX_GEMM_SERIALIZER_STALL_CNT_EN to count
// output backpressure cycles on stall_cnt_o (otherwise it is tied to 0).
module snax_gemm_result_serializer
   import snax_gemm_ser_pkg::*;
#(
   parameter int unsigned InWidth  = DefInWidth,
   parameter int unsigned OutWidth = DefOutWidth,
   parameter int unsigned CntWidth = DefCntWidth
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   snax_gemm_result_serializer_if.slave bus,
   input  logic                         clear_i,
   output logic                         busy_o,
   output logic [CntWidth-1:0]          stall_cnt_o
);
   localparam int unsigned Beats = ser_num_beats(InWidth, OutWidth);
   localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;

   if (((InWidth % OutWidth) != 0) || (Beats < 2)) begin : g_bad_width
      $error("InWidth must be an integer multiple (>=2) of OutWidth");
   end

   ser_state_e                       state_q, state_d;
   logic [IdxW-1:0]                  idx_q, idx_d;
   logic [Beats-1:0][OutWidth-1:0]   word_q, word_d;

   logic out_valid;
   logic out_hs;
   logic last_beat;
   logic in_ready;
   logic in_hs;

   assign out_valid = (state_q == SER_SEND);
   assign out_hs    = out_valid && bus.out_ready_i;
   assign last_beat = (idx_q == IdxW'(Beats - 1));
   // Accept in IDLE, or in SEND only while the final beat is leaving;
   // clear blocks acceptance so an aborted cycle cannot load a word.
   assign in_ready  = !clear_i && ((state_q == SER_IDLE) || (out_hs && last_beat));
   assign in_hs     = bus.in_valid_i && in_ready;

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = word_q[idx_q];
   assign busy_o          = out_valid;

   // Next state: clear > load new word > advance beat index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      if (clear_i) begin
         state_d = SER_IDLE;
         idx_d   = '0;
         word_d  = '0;
      end else if (in_hs) begin
         state_d = SER_SEND;
         idx_d   = '0;
         word_d  = bus.in_data_i;
      end else if (out_hs) begin
         if (last_beat) begin
            state_d = SER_IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end
   end

   // State, beat index and word register; reset abandons any held word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SER_IDLE;
         idx_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
      end
   end

`ifdef SNAX_GEMM_SERIALIZER_STALL_CNT_EN
   logic stall_en;
   assign stall_en = out_valid && !bus.out_ready_i;

   snax_gemm_ser_stall_counter #(
      .CntWidth (CntWidth)
   ) i_stall_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .en_i    (stall_en),
      .cnt_o   (stall_cnt_o)
   );
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snax_gemm_result_serializer.sv
// Directed + table-driven bench for snax_gemm_result_serializer with a
// randomized scoreboard phase. Honors SNAX_GEMM_SERIALIZER_STALL_CNT_EN.
module tb_snax_gemm_result_serializer;
   import snax_gemm_ser_pkg::*;

   localparam int unsigned InW   = 2048;
   localparam int unsigned OutW  = 512;
   localparam int unsigned CntW  = 32;
   localparam int unsigned Beats = 4;

`ifdef SNAX_GEMM_SERIALIZER_STALL_CNT_EN
   localparam int unsigned ExpStall5 = 5;
   localparam int unsigned ExpStall6 = 6;
`else
   localparam int unsigned ExpStall5 = 0;
   localparam int unsigned ExpStall6 = 0;
`endif

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic            clear = 1'b0;
   logic            busy;
   logic [CntW-1:0] stall_cnt;

   snax_gemm_result_serializer_if #(.InWidth(InW), .OutWidth(OutW)) bus ();

   snax_gemm_result_serializer #(
      .InWidth  (InW),
      .OutWidth (OutW),
      .CntWidth (CntW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .clear_i     (clear),
      .busy_o      (busy),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [OutW-1:0] act, input logic [OutW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [OutW-1:0] mk_beat(input int id);
      return {16{32'(id)}};
   endfunction

   function automatic logic [InW-1:0] mk_word(input int base);
      logic [InW-1:0] w;
      for (int k = 0; k < Beats; k++) w[k*OutW +: OutW] = mk_beat(base + k);
      return w;
   endfunction

   typedef struct {
      logic iv;    // in_valid_i
      int   base;  // word id base (beat k carries base+k)
      logic ordy;  // out_ready_i
      logic ir;    // expected in_ready_o
      logic ov;    // expected out_valid_o
      logic bsy;   // expected busy_o
      int   beat;  // expected beat id when ov
   } vec_t;

   vec_t vt[$];

   // Sample one cycle: drive at negedge, check combinational view #1 later.
   task automatic step(input logic iv, input int base, input logic ordy);
      @(negedge clk);
      bus.in_valid_i  = iv;
      bus.in_data_i   = mk_word(base);
      bus.out_ready_i = ordy;
      #1;
   endtask

   initial begin
      logic [OutW-1:0] q[$];
      logic [InW-1:0]  cur;
      int words_in, beats_ok, cyc;
      logic accepted, hs_in, hs_out;

      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.out_ready_i = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset out_valid", OutW'(bus.out_valid_o), '0);
      chk("reset busy",      OutW'(busy), '0);
      chk("reset stall_cnt", OutW'(stall_cnt), '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-reset in_ready", OutW'(bus.in_ready_o), OutW'(1));

      // Single word C(0), then A(16) with held-off B(32) streamed back to back.
      //                iv   base ordy  ir   ov   bsy  beat
      vt.push_back('{1'b1,  0, 1'b1, 1'b1, 1'b0, 1'b0, -1});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1,  0});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1,  1});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1,  2});
      vt.push_back('{1'b0,  0, 1'b1, 1'b1, 1'b1, 1'b1,  3});
      vt.push_back('{1'b1, 16, 1'b1, 1'b1, 1'b0, 1'b0, -1});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 16});
      vt.push_back('{1'b1, 32, 1'b1, 1'b0, 1'b1, 1'b1, 17});
      vt.push_back('{1'b1, 32, 1'b1, 1'b0, 1'b1, 1'b1, 18});
      vt.push_back('{1'b1, 32, 1'b1, 1'b1, 1'b1, 1'b1, 19});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 32});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 33});
      vt.push_back('{1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 34});
      vt.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 35});
      vt.push_back('{1'b0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 35});
      vt.push_back('{1'b0,  0, 1'b1, 1'b1, 1'b0, 1'b0, -1});

      foreach (vt[i]) begin
         step(vt[i].iv, vt[i].base, vt[i].ordy);
         chk($sformatf("vec%0d in_ready", i),  OutW'(bus.in_ready_o),  OutW'(vt[i].ir));
         chk($sformatf("vec%0d out_valid", i), OutW'(bus.out_valid_o), OutW'(vt[i].ov));
         chk($sformatf("vec%0d busy", i),      OutW'(busy),            OutW'(vt[i].bsy));
         if (vt[i].ov) chk($sformatf("vec%0d data", i), bus.out_data_o, mk_beat(vt[i].beat));
      end

      // Clear in idle zeroes the counter and blocks acceptance.
      @(negedge clk);
      clear = 1'b1;
      bus.in_valid_i = 1'b1;
      #1;
      chk("clear idle in_ready", OutW'(bus.in_ready_o), '0);
      @(negedge clk);
      clear = 1'b0;
      bus.in_valid_i = 1'b0;
      #1;
      chk("clear idle no capture", OutW'(bus.out_valid_o), '0);
      chk("stall before stall seq", OutW'(stall_cnt), '0);

      // Backpressure for 5 cycles during beat 1.
      step(1'b1, 48, 1'b1);
      chk("stall accept", OutW'(bus.in_ready_o), OutW'(1));
      step(1'b0, 0, 1'b1);
      chk("stall beat0", bus.out_data_o, mk_beat(48));
      for (int s = 0; s < 5; s++) begin
         step(1'b0, 0, 1'b0);
         chk($sformatf("stall%0d valid", s), OutW'(bus.out_valid_o), OutW'(1));
         chk($sformatf("stall%0d data", s),  bus.out_data_o, mk_beat(49));
      end
      step(1'b0, 0, 1'b1);
      chk("stall release data", bus.out_data_o, mk_beat(49));
      chk("stall count", OutW'(stall_cnt), OutW'(ExpStall5));
      step(1'b0, 0, 1'b1);
      chk("stall beat2", bus.out_data_o, mk_beat(50));
      step(1'b0, 0, 1'b1);
      chk("stall beat3", bus.out_data_o, mk_beat(51));
      step(1'b0, 0, 1'b1);
      chk("stall done", OutW'(bus.out_valid_o), '0);

      // clear_i at beat 2 with a competing input word.
      step(1'b1, 64, 1'b1);
      chk("clr accept", OutW'(bus.in_ready_o), OutW'(1));
      step(1'b0, 0, 1'b0);
      chk("clr beat0 stalled", bus.out_data_o, mk_beat(64));
      step(1'b0, 0, 1'b1);
      chk("clr stall count", OutW'(stall_cnt), OutW'(ExpStall6));
      step(1'b0, 0, 1'b1);
      chk("clr beat1", bus.out_data_o, mk_beat(65));
      @(negedge clk);
      clear = 1'b1;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = mk_word(80);
      #1;
      chk("clr beat2", bus.out_data_o, mk_beat(66));
      chk("clr in_ready", OutW'(bus.in_ready_o), '0);
      @(negedge clk);
      clear = 1'b0;
      bus.in_valid_i = 1'b0;
      #1;
      chk("clr out_valid", OutW'(bus.out_valid_o), '0);
      chk("clr busy", OutW'(busy), '0);
      chk("clr stall_cnt", OutW'(stall_cnt), '0);
      chk("clr in_ready after", OutW'(bus.in_ready_o), OutW'(1));
      for (int s = 0; s < 3; s++) begin
         step(1'b0, 0, 1'b1);
         chk($sformatf("clr no capture%0d", s), OutW'(bus.out_valid_o), '0);
      end

      // Asynchronous reset in the middle of beat 1.
      step(1'b1, 96, 1'b1);
      step(1'b0, 0, 1'b1);
      chk("rst beat0", bus.out_data_o, mk_beat(96));
      step(1'b0, 0, 1'b0);
      chk("rst beat1", bus.out_data_o, mk_beat(97));
      rst_n = 1'b0;
      #1;
      chk("rst async out_valid", OutW'(bus.out_valid_o), '0);
      chk("rst async busy", OutW'(busy), '0);
      chk("rst async stall", OutW'(stall_cnt), '0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;
      for (int s = 0; s < 4; s++) begin
         step(1'b0, 0, 1'b1);
         chk($sformatf("rst no stale%0d", s), OutW'(bus.out_valid_o), '0);
         chk($sformatf("rst in_ready%0d", s), OutW'(bus.in_ready_o), OutW'(1));
      end

      // Random valid/ready, 1000 words, scoreboarded LSB-first.
      words_in = 0;
      beats_ok = 0;
      cyc      = 0;
      accepted = 1'b0;
      bus.in_valid_i = 1'b0;
      while (((words_in < 1000) || (q.size() > 0)) && (cyc < 60000)) begin
         @(negedge clk);
         cyc++;
         if (accepted) bus.in_valid_i = 1'b0;
         accepted = 1'b0;
         if (!bus.in_valid_i && (words_in < 1000) && ($urandom_range(1, 0) == 1)) begin
            for (int j = 0; j < InW / 32; j++) cur[j*32 +: 32] = $urandom();
            bus.in_data_i  = cur;
            bus.in_valid_i = 1'b1;
         end
         bus.out_ready_i = ($urandom_range(3, 0) != 0);
         #1;
         hs_in  = bus.in_valid_i && bus.in_ready_o;
         hs_out = bus.out_valid_o && bus.out_ready_i;
         if (hs_out) begin
            if (q.size() == 0) begin
               chk("rand spurious beat", OutW'(1), '0);
            end else begin
               chk($sformatf("rand beat%0d", beats_ok), bus.out_data_o, q.pop_front());
               beats_ok++;
            end
         end
         if (hs_in) begin
            for (int k = 0; k < Beats; k++) q.push_back(bus.in_data_i[k*OutW +: OutW]);
            words_in++;
            accepted = 1'b1;
         end
      end
      chk("rand timeout", OutW'(cyc >= 60000), '0);
      chk("rand words", OutW'(words_in), OutW'(1000));
      chk("rand beats", OutW'(beats_ok), OutW'(4000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/snax_gemm_result_serializer.md
SNAX_GEMM_RESULT_SERIALIZER -- requirements
Module: snax_gemm_result_serializer

Interface
- REQ-001: Parameter InWidth, default 2048, SHALL set the width of one GEMM result word (C tile).
- REQ-002: Parameter OutWidth, default 512, SHALL set the width of one streamer write beat; InWidth SHALL be an integer multiple (>=2) of OutWidth, checked by elaboration assertion.
- REQ-003: Parameter CntWidth, default 32, SHALL set the width of the stall counter.
- REQ-004: clk_i  input  1  the single clock; all state rising-edge triggered.
- REQ-005: rst_ni  input  1  reset, asynchronous and active-low.
- REQ-006: in_data_i  input  InWidth  result word from the GEMM core.
- REQ-007: in_valid_i  input  1  result word valid.
- REQ-008: in_ready_o  output  1  serializer can accept a word.
- REQ-009: out_data_o  output  OutWidth  beat to the write streamer.
- REQ-010: out_valid_o  output  1  beat valid.
- REQ-011: out_ready_i  input  1  streamer accepts beat.
- REQ-012: clear_i  input  1  synchronous abort and flush.
- REQ-013: busy_o  output  1  high while a word is held.
- REQ-014: stall_cnt_o  output  CntWidth  output backpressure cycle count.

Function
- REQ-015: Beats = InWidth/OutWidth; the design SHALL hold a word register, a beat index of clog2(Beats) bits and a two-state FSM IDLE/SEND.
- REQ-016: IDLE: in_ready_o=1, out_valid_o=0; in_valid_i&&in_ready_o SHALL capture in_data_i, set index 0, go to SEND.
- REQ-017: SEND: out_valid_o=1, out_data_o=word[index*OutWidth +: OutWidth], LSB slice first; contents SHALL stay stable while out_valid_o&&!out_ready_i.
- REQ-018: Each out handshake in SEND SHALL increment index; handshake at index Beats-1 SHALL end the word.
- REQ-019: in_ready_o SHALL be 1 in SEND only during the last-beat handshake cycle (combinational on out_ready_i); a simultaneous input handshake SHALL load the new word, index 0, remain SEND (no bubble).
- REQ-020: Last-beat handshake without input handshake SHALL return to IDLE.
- REQ-021: Latency: first beat valid exactly 1 cycle after input handshake; sustained throughput one word per Beats cycles when out_ready_i=1.
- REQ-022: busy_o SHALL equal (state==SEND).
- REQ-023: clear_i SHALL, next edge, force IDLE, index 0, discard held word, ignore any same-cycle input handshake (in_ready_o=0 while clear_i=1), and zero the stall counter.
- REQ-024: in_valid_i in SEND before the last beat SHALL be held off (in_ready_o=0), never dropped.

Reset
- REQ-025: While rst_ni=0: state IDLE, index 0, word register 0, out_valid_o=0, busy_o=0, stall_cnt_o=0, in_ready_o=1 after release.
- REQ-026: Reset assertion mid-word SHALL abandon the word asynchronously; no beat emitted after release without a new input.

Configuration
- REQ-027: Macro SNAX_GEMM_SERIALIZER_STALL_CNT_EN defined: stall_cnt_o SHALL count cycles with out_valid_o&&!out_ready_i, saturate at all-ones, clear on clear_i.
- REQ-028: Macro undefined: stall_cnt_o SHALL be constant 0, no counter flops; port list identical both ways.

Structure
- REQ-029: Package snax_gemm_ser_pkg SHALL hold the FSM state enum and default width constants.
- REQ-030: Sub-module snax_gemm_ser_stall_counter (saturating, clearable) SHALL implement REQ-027 and be instantiated only under the macro.

Verification
- REQ-031: Word 0x...0003_...0002_...0001_...0000 (beat k = k), out_ready_i=1 -> beats 0,1,2,3 on cycles 1-4 after accept, busy_o falls after beat 3.
- REQ-032: Two back-to-back words, out_ready_i=1 -> 8 consecutive valid beats, no bubble, second accept coincides with first word's beat 3.
- REQ-033: out_ready_i low 5 cycles during beat 1 -> beat 1 data held stable; stall_cnt_o=5 (macro on) or 0 (macro off).
- REQ-034: clear_i pulsed at beat 2 with in_valid_i=1 -> out_valid_o=0 next cycle, new word not captured, stall_cnt_o=0.
- REQ-035: rst_ni asserted mid-beat 1 -> outputs at reset values immediately; no stale beat after release.
- REQ-036: Random valid/ready, 1000 words -> scoreboard output stream equals inputs split LSB-first, no loss or duplication.
